// File: rtl/lamp_pkg.sv
// Shared mode encoding and constants for the lamp sequencer and its decoder interface.
package lamp_pkg;

  typedef enum logic [2:0] {
    MODE_OFF    = 3'd0,
    MODE_LEFT   = 3'd1,
    MODE_RIGHT  = 3'd2,
    MODE_BOUNCE = 3'd3,
    MODE_CUSTOM = 3'd4
  } mode_t;

  localparam logic [3:0] SEL_CFG       = 4'h8;
  localparam logic [2:0] POS_MIN       = 3'd0;
  localparam logic [2:0] POS_MAX       = 3'd7;
  localparam logic [7:0] RESET_PATTERN = 8'h01;

  // Button order: OFF -> LEFT -> RIGHT -> BOUNCE -> CUSTOM -> OFF.
  function automatic mode_t advance_mode(input mode_t m);
    if (m == MODE_CUSTOM) return MODE_OFF;
    return mode_t'(m + 3'd1);
  endfunction

endpackage

// File: rtl/lamp_sequencer_if.sv
// Control inputs and decoder-facing outputs of the lamp sequencer.
interface lamp_sequencer_if;
  logic       enable;
  logic       mode_next;
  logic       cfg_load;
  logic [7:0] cfg_in;
  logic [3:0] sel;
  logic [7:0] cfg_out;
  logic [2:0] mode;
  logic       step;

  modport master (
    output enable, mode_next, cfg_load, cfg_in,
    input  sel, cfg_out, mode, step
  );

  modport slave (
    input  enable, mode_next, cfg_load, cfg_in,
    output sel, cfg_out, mode, step
  );
endinterface

// File: rtl/lamp_prescaler.sv
// Step-rate prescaler: one tick every TICK_DIV enabled cycles, clearable on mode entry.
module lamp_prescaler #(
  parameter int TICK_DIV = 25_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);

  logic [CW-1:0] count_reg;

  assign tick = enable && (count_reg == CW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= tick ? '0 : count_reg + CW'(1);
    end
  end

endmodule

// File: rtl/lamp_sequencer.sv
// Mode FSM, lamp position/direction and custom-pattern rotation feeding decoder48.
module lamp_sequencer
  import lamp_pkg::*;
#(
  parameter int TICK_DIV = 25_000_000
) (
  input  logic                   clk,
  input  logic                   reset,
  lamp_sequencer_if.slave        bus
);

  mode_t      state_reg, state_next;
  logic [2:0] pos_reg;
  logic       dir_up_reg;
  logic [7:0] pattern_reg;
  logic [7:0] rot_reg;
  logic       prev_reg;
  logic       step_reg;
  logic       tick;
  logic       press;
  logic       custom_load;
  logic       advance;

  // prev_reg resets high so a button held through reset is not a press.
  assign press       = bus.mode_next && !prev_reg;
  assign custom_load = bus.cfg_load && (state_reg == MODE_CUSTOM);
  assign advance     = tick && !press && !custom_load && (state_reg != MODE_OFF);

  lamp_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .enable (bus.enable),
    .clear  (press),
    .tick   (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) state_reg <= MODE_OFF;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (press) state_next = advance_mode(state_reg);
  end

  always_comb begin
    bus.sel     = SEL_CFG;
    bus.cfg_out = 8'h00;
    case (state_reg)
      MODE_LEFT, MODE_RIGHT, MODE_BOUNCE: bus.sel     = {1'b0, pos_reg};
      MODE_CUSTOM:                        bus.cfg_out = rot_reg;
      default: ;
    endcase
    bus.mode = state_reg;
    bus.step = step_reg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pos_reg     <= POS_MIN;
      dir_up_reg  <= 1'b1;
      pattern_reg <= RESET_PATTERN;
      rot_reg     <= RESET_PATTERN;
      prev_reg    <= 1'b1;
      step_reg    <= 1'b0;
    end else begin
      prev_reg <= bus.mode_next;
      step_reg <= advance;
      if (press) begin
        pos_reg    <= (state_next == MODE_RIGHT) ? POS_MAX : POS_MIN;
        dir_up_reg <= 1'b1;
        rot_reg    <= pattern_reg;
      end else begin
        if (bus.cfg_load) begin
          pattern_reg <= bus.cfg_in;
          if (state_reg == MODE_CUSTOM) rot_reg <= bus.cfg_in;
        end
        if (advance) begin
          case (state_reg)
            MODE_LEFT:  pos_reg <= pos_reg + 3'd1;
            MODE_RIGHT: pos_reg <= pos_reg - 3'd1;
            MODE_BOUNCE: begin
              // Flip on arrival at an end so the end value is shown only once.
              if (dir_up_reg) begin
                pos_reg <= pos_reg + 3'd1;
                if (pos_reg == POS_MAX - 3'd1) dir_up_reg <= 1'b0;
              end else begin
                pos_reg <= pos_reg - 3'd1;
                if (pos_reg == POS_MIN + 3'd1) dir_up_reg <= 1'b1;
              end
            end
            MODE_CUSTOM: rot_reg <= {rot_reg[6:0], rot_reg[7]};
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_lamp_sequencer.sv
// Self-checking bench for lamp_sequencer with TICK_DIV=4: directed table, corner sequences, random vs model.
module tb_lamp_sequencer;

  localparam int TICK_DIV = 4;

  logic clk = 1'b0;
  logic reset;
  lamp_sequencer_if bus();

  lamp_sequencer #(.TICK_DIV(TICK_DIV)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model: a step counter per mode, not a position/direction register.
  int         m_mode, m_phase, m_cnt;
  logic [7:0] m_pattern, m_rot;
  logic       m_prev, m_step;

  function automatic logic [3:0] model_sel();
    int p;
    case (m_mode)
      1: return 4'(m_phase % 8);
      2: return 4'(7 - (m_phase % 8));
      3: begin
        p = m_phase % 14;
        return 4'((p <= 7) ? p : 14 - p);
      end
      default: return 4'd8;
    endcase
  endfunction

  function automatic logic [7:0] model_cfg();
    return (m_mode == 4) ? m_rot : 8'h00;
  endfunction

  task automatic model_step(input logic rst, en, mn, ld, input logic [7:0] cin);
    bit tk, pr;
    if (rst) begin
      m_mode = 0; m_phase = 0; m_cnt = 0;
      m_pattern = 8'h01; m_rot = 8'h01; m_prev = 1'b1; m_step = 1'b0;
      return;
    end
    pr = mn && !m_prev;
    m_prev = mn;
    tk = en && (m_cnt == TICK_DIV - 1);
    if (en) m_cnt = (m_cnt + 1) % TICK_DIV;
    m_step = 1'b0;
    if (pr) begin
      m_mode = (m_mode + 1) % 5;
      m_phase = 0;
      m_cnt = 0;
      m_rot = m_pattern;
    end else begin
      if (ld) begin
        m_pattern = cin;
        if (m_mode == 4) m_rot = cin;
      end
      if (tk && m_mode != 0 && !(ld && m_mode == 4)) begin
        m_phase++;
        m_step = 1'b1;
        if (m_mode == 4) m_rot = 8'(((m_rot * 2) % 256) + (m_rot / 128));
      end
    end
  endtask

  task automatic check_outs(input string name, input logic [3:0] es, input logic [7:0] ec,
                            input logic [2:0] em, input logic est);
    vectors++;
    if (bus.sel !== es || bus.cfg_out !== ec || bus.mode !== em || bus.step !== est) begin
      miscompares++;
      $display("FAIL %s: got sel=%0d cfg=%02h mode=%0d step=%0d, expected sel=%0d cfg=%02h mode=%0d step=%0d",
               name, bus.sel, bus.cfg_out, bus.mode, bus.step, es, ec, em, est);
    end
  endtask

  task automatic cycle(input logic rst, en, mn, ld, input logic [7:0] cin);
    reset = rst; bus.enable = en; bus.mode_next = mn; bus.cfg_load = ld; bus.cfg_in = cin;
    @(posedge clk);
    model_step(rst, en, mn, ld, cin);
    #1;
    check_outs("model", model_sel(), model_cfg(), 3'(m_mode), m_step);
  endtask

  task automatic idle(); cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00); endtask

  task automatic press();
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    idle();
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    check_outs("reset", 4'd8, 8'h00, 3'd0, 1'b0);
    idle();
  endtask

  task automatic wait_step(input string name, input logic [3:0] es, input logic [7:0] ec,
                           input logic [2:0] em);
    bit found = 0;
    for (int i = 0; i < 3 * TICK_DIV && !found; i++) begin
      idle();
      if (bus.step === 1'b1) found = 1;
    end
    if (!found) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: got no step pulse, expected one within %0d cycles", name, 3 * TICK_DIV);
    end else begin
      check_outs(name, es, ec, em, 1'b1);
    end
  endtask

  typedef struct {
    logic       en;
    logic       mn;
    logic       ld;
    logic [7:0] cin;
    logic [3:0] sel;
    logic [7:0] cfg;
    logic [2:0] mode;
    logic       step;
  } vec_t;

  vec_t tbl[10];

  initial begin
    logic [3:0] left_exp[7];
    logic [3:0] right_exp[7];
    logic [3:0] bounce_exp[9];
    logic [7:0] rot_exp[3];

    tbl[0] = '{1'b1, 1'b0, 1'b0, 8'h00, 4'd8, 8'h00, 3'd0, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 8'h00, 3'd1, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 8'h00, 3'd1, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 8'h00, 3'd1, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 8'h00, 3'd1, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 8'h00, 4'd1, 8'h00, 3'd1, 1'b1};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 8'h00, 4'd1, 8'h00, 3'd1, 1'b0};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 8'h00, 4'd1, 8'h00, 3'd1, 1'b0};
    tbl[8] = '{1'b1, 1'b0, 1'b0, 8'h00, 4'd1, 8'h00, 3'd1, 1'b0};
    tbl[9] = '{1'b1, 1'b0, 1'b0, 8'h00, 4'd2, 8'h00, 3'd1, 1'b1};
    left_exp   = '{4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd0, 4'd1};
    right_exp  = '{4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd7};
    bounce_exp = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd6, 4'd5};
    rot_exp    = '{8'h07, 8'h0E, 8'h1C};

    reset = 1'b1; bus.enable = 1'b0; bus.mode_next = 1'b0; bus.cfg_load = 1'b0; bus.cfg_in = 8'h00;

    // Reset then LEFT, table driven.
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    check_outs("reset_state", 4'd8, 8'h00, 3'd0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, tbl[i].en, tbl[i].mn, tbl[i].ld, tbl[i].cin);
      check_outs($sformatf("table[%0d]", i), tbl[i].sel, tbl[i].cfg, tbl[i].mode, tbl[i].step);
    end
    for (int i = 0; i < 7; i++) wait_step($sformatf("left_step%0d", i), left_exp[i], 8'h00, 3'd1);

    // Mode change coinciding with a tick, then enable hold at count 2.
    do_reset();
    press();
    check_outs("enter_left", 4'd0, 8'h00, 3'd1, 1'b0);
    idle(); idle();
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    check_outs("mode_on_tick", 4'd7, 8'h00, 3'd2, 1'b0);
    idle(); idle();
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      check_outs($sformatf("enable_hold%0d", i), 4'd7, 8'h00, 3'd2, 1'b0);
    end
    idle();
    check_outs("resume1", 4'd7, 8'h00, 3'd2, 1'b0);
    idle();
    check_outs("resume2", 4'd6, 8'h00, 3'd2, 1'b1);
    for (int i = 0; i < 7; i++) wait_step($sformatf("right_step%0d", i), right_exp[i], 8'h00, 3'd2);

    // BOUNCE entry, CUSTOM with a load of 83, back to OFF.
    press();
    check_outs("enter_bounce", 4'd0, 8'h00, 3'd3, 1'b0);
    press();
    check_outs("enter_custom", 4'd8, 8'h01, 3'd4, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 8'h83);
    check_outs("custom_load", 4'd8, 8'h83, 3'd4, 1'b0);
    for (int i = 0; i < 3; i++) wait_step($sformatf("rot%0d", i), 4'd8, rot_exp[i], 3'd4);
    press();
    check_outs("custom_to_off", 4'd8, 8'h00, 3'd0, 1'b0);

    // Button held across reset must not count as a press.
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
    check_outs("held_reset", 4'd8, 8'h00, 3'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
      check_outs($sformatf("held%0d", i), 4'd8, 8'h00, 3'd0, 1'b0);
    end
    idle();
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    check_outs("fresh_press", 4'd0, 8'h00, 3'd1, 1'b0);

    // Reset mid-BOUNCE after loading F0: pattern must revert to 01.
    do_reset();
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 8'hF0);
    press(); press(); press();
    for (int i = 0; i < 9; i++) wait_step($sformatf("bounce%0d", i), bounce_exp[i], 8'h00, 3'd3);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    check_outs("reset_mid_bounce", 4'd8, 8'h00, 3'd0, 1'b0);
    idle();
    press(); press(); press(); press();
    check_outs("custom_after_reset", 4'd8, 8'h01, 3'd4, 1'b0);

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      cycle(($urandom % 300) == 0, ($urandom % 4) != 0, ($urandom % 10) == 0,
            ($urandom % 12) == 0, 8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
